// File: rtl/router_pkg.sv
// Shared constants and state type for the router input arbiter.
package router_pkg;

  localparam int ADDR_W             = 2;
  localparam int NUM_DST            = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/router_arbiter_if.sv
// Requester/destination handshake bundle between the requesters and the router arbiter.
interface router_arbiter_if #(
  parameter int DATA_WIDTH = router_pkg::DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4
) ();
  import router_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_DST-1:0]            dst_ready;
  logic [DATA_WIDTH-1:0]         din;
  logic                          din_en;
  logic [ADDR_W-1:0]             addr;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_addr, req_last, dst_ready,
    output req_ready, din, din_en, addr, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_addr, req_last, dst_ready,
    input  req_ready, din, din_en, addr, grant_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               valid_o
);

  int idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    // Offset 1 first so the previous winner is scanned last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (!valid_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Packet-locking round-robin arbiter feeding one router input with registered beats.
module router_arbiter #(
  parameter int DATA_WIDTH = router_pkg::DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4
) (
  input  logic             clk,
  input  logic             rst,
  router_arbiter_if.slave  bus
);
  import router_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                state_q;
  logic [ID_W-1:0]       lock_id_q;
  logic [ADDR_W-1:0]     lock_addr_q;
  logic [ID_W-1:0]       last_grant_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  din_en_q;
  logic [ADDR_W-1:0]     addr_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    rr_grant;
  logic                  rr_valid;
  logic [NUM_REQ-1:0]    ready;
  logic                  accept;
  int                    acc_idx;
  logic                  acc_last;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] & bus.dst_ready[bus.req_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant),
    .valid_o      (rr_valid)
  );

  // While locked only the owner may move, and only when its port can take data.
  always_comb begin
    ready   = '0;
    acc_idx = 0;
    if (state_q == IDLE) begin
      if (rr_valid) begin
        ready = rr_grant;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rr_grant[i]) begin
          acc_idx = i;
        end
      end
    end else begin
      ready[lock_id_q] = bus.dst_ready[lock_addr_q];
      acc_idx          = int'(lock_id_q);
    end
    accept   = |(ready & bus.req_valid);
    acc_last = bus.req_last[acc_idx];
    acc_data = bus.req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];
    acc_addr = (state_q == IDLE) ? bus.req_addr[acc_idx*ADDR_W +: ADDR_W] : lock_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lock_id_q    <= '0;
      lock_addr_q  <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      din_q        <= '0;
      din_en_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      din_en_q <= accept;
      din_q    <= accept ? acc_data : '0;
      addr_q   <= accept ? acc_addr : '0;
      if (accept) begin
        last_grant_q <= ID_W'(acc_idx);
      end
      case (state_q)
        IDLE: begin
          if (accept && !acc_last) begin
            state_q     <= BURST;
            lock_id_q   <= ID_W'(acc_idx);
            lock_addr_q <= acc_addr;
          end
        end
        BURST: begin
          if (accept && acc_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.din       = din_q;
  assign bus.din_en    = din_en_q;
  assign bus.addr      = addr_q;
  assign bus.grant_id  = last_grant_q;
  assign bus.busy      = (state_q == BURST);

endmodule

// File: tb/tb_router_arbiter.sv
// Directed-vector bench for router_arbiter: round robin, bursts, stalls, port blocking, reset.
module tb_router_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  router_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  router_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic valid, input logic [1:0] dst,
                               input logic last, input logic [31:0] data);
    bus.req_valid[id]         = valid;
    bus.req_addr[id*2 +: 2]   = dst;
    bus.req_last[id]          = last;
    bus.req_data[id*DW +: DW] = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic en, input logic [31:0] data, input logic [1:0] dst);
    checkOutput({tag, ".din_en"}, 64'(bus.din_en), 64'(en));
    checkOutput({tag, ".din"},    64'(bus.din),    64'(data));
    checkOutput({tag, ".addr"},   64'(bus.addr),   64'(dst));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_addr  = '0;
    bus.req_last  = '0;
    bus.dst_ready = 4'hF;

    // Reset values, with requester 0 lined up to win first.
    #12;
    checkBeat("reset", 1'b0, 32'h0, 2'd0);
    checkOutput("reset.busy",      64'(bus.busy),      64'd0);
    checkOutput("reset.grant_id",  64'(bus.grant_id),  64'd3);
    checkOutput("reset.req_ready", 64'(bus.req_ready), 64'd0);

    // Full contention, single-beat packets: grants rotate with no bubble.
    rst = 1'b1;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 2'd0, 1'b1, 32'h100 + 32'(i));
    settle();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr%0d.req_ready", k), 64'(bus.req_ready), 64'(4'b0001 << (k % NR)));
      step();
      checkBeat($sformatf("rr%0d", k), 1'b1, 32'h100 + 32'(k % NR), 2'd0);
      checkOutput($sformatf("rr%0d.grant_id", k), 64'(bus.grant_id), 64'(k % NR));
    end

    // Idle stretch: outputs zero, grant_id holds the last winner.
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 2'd0, 1'b1, 32'h0);
    settle();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("idle%0d.req_ready", k), 64'(bus.req_ready), 64'd0);
      step();
      checkBeat($sformatf("idle%0d", k), 1'b0, 32'h0, 2'd0);
      checkOutput($sformatf("idle%0d.grant_id", k), 64'(bus.grant_id), 64'd0);
    end

    // Three-beat packet from requester 2 to port 1 locks out requester 0.
    applyStimulus(0, 1'b1, 2'd0, 1'b1, 32'h50);
    applyStimulus(2, 1'b1, 2'd1, 1'b0, 32'hA);
    settle();
    checkOutput("pkt.a.req_ready", 64'(bus.req_ready), 64'b0100);
    step();
    checkBeat("pkt.a", 1'b1, 32'hA, 2'd1);
    checkOutput("pkt.a.busy",     64'(bus.busy),     64'd1);
    checkOutput("pkt.a.grant_id", 64'(bus.grant_id), 64'd2);
    applyStimulus(2, 1'b1, 2'd3, 1'b0, 32'hB);
    settle();
    checkOutput("pkt.b.req_ready", 64'(bus.req_ready), 64'b0100);
    step();
    checkBeat("pkt.b", 1'b1, 32'hB, 2'd1);
    checkOutput("pkt.b.busy", 64'(bus.busy), 64'd1);
    applyStimulus(2, 1'b1, 2'd1, 1'b1, 32'hC);
    settle();
    checkOutput("pkt.c.req_ready", 64'(bus.req_ready), 64'b0100);
    step();
    checkBeat("pkt.c", 1'b1, 32'hC, 2'd1);
    checkOutput("pkt.c.busy", 64'(bus.busy), 64'd0);
    applyStimulus(2, 1'b0, 2'd1, 1'b1, 32'h0);
    settle();
    checkOutput("pkt.r0.req_ready", 64'(bus.req_ready), 64'b0001);
    step();
    checkBeat("pkt.r0", 1'b1, 32'h50, 2'd0);
    checkOutput("pkt.r0.grant_id", 64'(bus.grant_id), 64'd0);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h0);
    settle();

    // Mid-burst stall on port 1 for three cycles; nobody else is served.
    applyStimulus(2, 1'b1, 2'd1, 1'b0, 32'h11);
    settle();
    step();
    checkBeat("stall.b1", 1'b1, 32'h11, 2'd1);
    applyStimulus(2, 1'b1, 2'd1, 1'b0, 32'h12);
    step();
    checkBeat("stall.b2", 1'b1, 32'h12, 2'd1);
    applyStimulus(2, 1'b1, 2'd1, 1'b0, 32'h13);
    applyStimulus(0, 1'b1, 2'd0, 1'b1, 32'h60);
    bus.dst_ready = 4'b1101;
    settle();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("stall%0d.req_ready", k), 64'(bus.req_ready), 64'd0);
      step();
      checkBeat($sformatf("stall%0d", k), 1'b0, 32'h0, 2'd0);
      checkOutput($sformatf("stall%0d.busy", k), 64'(bus.busy), 64'd1);
    end
    bus.dst_ready = 4'hF;
    settle();
    checkOutput("stall.resume.req_ready", 64'(bus.req_ready), 64'b0100);
    step();
    checkBeat("stall.b3", 1'b1, 32'h13, 2'd1);
    checkOutput("stall.b3.busy", 64'(bus.busy), 64'd1);
    applyStimulus(2, 1'b1, 2'd1, 1'b1, 32'h14);
    step();
    checkBeat("stall.b4", 1'b1, 32'h14, 2'd1);
    checkOutput("stall.b4.busy", 64'(bus.busy), 64'd0);
    applyStimulus(2, 1'b0, 2'd1, 1'b1, 32'h0);
    settle();
    checkOutput("stall.r0.req_ready", 64'(bus.req_ready), 64'b0001);
    step();
    checkBeat("stall.r0", 1'b1, 32'h60, 2'd0);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h0);
    settle();

    // Requester 1 blocked on port 3; requester 3 to port 0 goes first.
    applyStimulus(1, 1'b1, 2'd3, 1'b1, 32'h71);
    applyStimulus(3, 1'b1, 2'd0, 1'b1, 32'h73);
    bus.dst_ready = 4'b0111;
    settle();
    checkOutput("block.req_ready", 64'(bus.req_ready), 64'b1000);
    step();
    checkBeat("block.r3", 1'b1, 32'h73, 2'd0);
    checkOutput("block.r3.grant_id", 64'(bus.grant_id), 64'd3);
    applyStimulus(3, 1'b0, 2'd0, 1'b1, 32'h0);
    settle();
    checkOutput("block.wait.req_ready", 64'(bus.req_ready), 64'd0);
    step();
    checkBeat("block.wait", 1'b0, 32'h0, 2'd0);
    bus.dst_ready = 4'hF;
    settle();
    checkOutput("block.open.req_ready", 64'(bus.req_ready), 64'b0010);
    step();
    checkBeat("block.r1", 1'b1, 32'h71, 2'd3);
    checkOutput("block.r1.grant_id", 64'(bus.grant_id), 64'd1);
    applyStimulus(1, 1'b0, 2'd3, 1'b1, 32'h0);
    settle();

    // Reset in the middle of a burst drops the lock immediately.
    applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h81);
    settle();
    checkOutput("rstb.req_ready", 64'(bus.req_ready), 64'b0010);
    step();
    checkBeat("rstb.b1", 1'b1, 32'h81, 2'd2);
    checkOutput("rstb.busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    settle();
    checkBeat("rstb.async", 1'b0, 32'h0, 2'd0);
    checkOutput("rstb.async.busy",     64'(bus.busy),     64'd0);
    checkOutput("rstb.async.grant_id", 64'(bus.grant_id), 64'd3);
    step();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 2'd0, 1'b1, 32'h90 + 32'(i));
    settle();
    checkOutput("rstb.after.req_ready", 64'(bus.req_ready), 64'b0001);
    step();
    checkBeat("rstb.after", 1'b1, 32'h90, 2'd0);
    checkOutput("rstb.after.grant_id", 64'(bus.grant_id), 64'd0);
    checkOutput("rstb.after.busy",     64'(bus.busy),     64'd0);
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 2'd0, 1'b1, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_arbiter.md
ROUTER_ARBITER -- requirements
Module: router_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each data beat.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 req_data  input  NUM_REQ*DATA_WIDTH  per-requester beat data, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req_addr  input  NUM_REQ*2  per-requester destination port (0..3).
REQ-008 req_last  input  NUM_REQ  marks final beat of a packet.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; combinational, at most one bit high.
REQ-010 dst_ready  input  4  per-destination-port can-accept flag.
REQ-011 din  output  DATA_WIDTH  registered beat data to the router.
REQ-012 din_en  output  1  registered beat strobe to the router.
REQ-013 addr  output  2  registered destination port to the router.
REQ-014 grant_id  output  $clog2(NUM_REQ)  id of the current or most recent granted requester.
REQ-015 busy  output  1  high while a multi-beat packet holds the lock.

Function
REQ-016 Beat accepted when req_valid[i] & req_ready[i] in cycle N; it SHALL appear on din/addr with din_en=1 in cycle N+1 for exactly one cycle.
REQ-017 No acceptance in cycle N -> din_en=0, din=0, addr=0 in cycle N+1.
REQ-018 Requester i eligible in IDLE iff req_valid[i] & dst_ready[req_addr[i]].
REQ-019 States: IDLE (no lock), BURST (locked requester lock_id, locked port lock_addr).
REQ-020 IDLE: grant the first eligible requester scanning from last_grant+1 upward, modulo NUM_REQ; none eligible -> all req_ready=0.
REQ-021 IDLE grant with req_last=1 -> stay IDLE; req_last=0 -> BURST, lock_id=i, lock_addr=req_addr[i].
REQ-022 BURST: req_ready[lock_id] = dst_ready[lock_addr]; all other req_ready=0.
REQ-023 BURST: beats use lock_addr; req_addr of the locked requester is ignored after the first beat.
REQ-024 BURST: accepted beat with req_last=1 -> IDLE next cycle.
REQ-025 last_grant updates to the granted id on every accepted beat; grant_id equals last_grant.
REQ-026 busy=1 exactly while state is BURST.
REQ-027 dst_ready[lock_addr]=0 or req_valid[lock_id]=0 in BURST -> stall, hold lock, serve no other requester; no timeout.
REQ-028 Single-beat packets SHALL be accepted back-to-back every cycle with no idle bubble.
REQ-029 Requesters hold valid/data/addr/last stable until accepted; the block does not check this.

Reset
REQ-030 rst=0 SHALL asynchronously force state=IDLE, din=0, din_en=0, addr=0, busy=0, last_grant=NUM_REQ-1 (grant_id=NUM_REQ-1), so requester 0 has first priority.
REQ-031 Reset during BURST SHALL drop the lock; the partial packet is not resumed.

Structure
REQ-032 Package router_pkg SHALL hold ADDR_W=2, NUM_DST=4, DATA_WIDTH default and the state enum typedef (IDLE, BURST).
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs eligible vector and last_grant; outputs one-hot grant and valid).
REQ-034 Output registers and FSM live in router_arbiter.

Verification
REQ-035 After reset, req_valid=4'b1111, all last=1, all dst_ready=1 -> grants 0,1,2,3,0 in consecutive cycles; din_en high each cycle from the second.
REQ-036 Req 2 sends 3-beat packet to port 1 (data 0xA,0xB,0xC) while req 0 valid -> din 0xA,0xB,0xC, addr=1, busy=1 for 2 cycles, req 0 granted only after 0xC.
REQ-037 Mid-burst dst_ready[1]=0 for 3 cycles -> din_en=0 for those cycles, req_ready all 0, burst resumes with next beat, no reordering.
REQ-038 Req 1 targets port 3 with dst_ready[3]=0, req 3 targets port 0 ready -> req 3 granted, req 1 waits until dst_ready[3]=1.
REQ-039 rst=0 asserted mid-burst -> din_en, busy drop immediately; after release, requester 0 wins a full contention.
REQ-040 No valids for 5 cycles -> din=0, addr=0, din_en=0, grant_id unchanged.
